uart_tx_fifo: RTL and testbench

//  Byte FIFO between the CPU bus write side and the UART transmitter. Accepts bytes
//  on a single-cycle write strobe, buffers up to 2**DEPTH_LOG2 of them, and hands

---
 rtl/uart_tx_fifo_if.sv | 26 ++
 rtl/uart_tx_fifo.sv | 125 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the CPU write side, the byte FIFO and the UART transmitter.
// master = bus/transmitter side driving the FIFO, slave = the FIFO itself.
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  flush;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  tx_ready;
    logic [7:0]            tx_data;
    logic                  tx_busy;

    modport master (
        output wr_en, wr_data, flush, tx_busy,
        input  full, empty, count, overflow, tx_ready, tx_data
    );

    modport slave (
        input  wr_en, wr_data, flush, tx_busy,
        output full, empty, count, overflow, tx_ready, tx_data
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: single-cycle pushes in, one byte at a time out
// through a tx_ready pulse / tx_busy handshake. Flags are registered views of the count.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic         clk,
    input  logic         reset,
    uart_tx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [7:0]             mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]    count_q, count_d;
    logic                   full_q, full_d;
    logic                   empty_q, empty_d;
    logic                   ovf_q, ovf_d;
    logic                   rdy_q, rdy_d;
    logic [7:0]             data_q, data_d;

    logic push, drop, pop;

    // Full is the registered pre-edge view, so a push that meets a same-cycle pop
    // while full is still dropped.
    always_comb begin
        push = bus.wr_en && !full_q && !bus.flush;
        drop = bus.wr_en &&  full_q && !bus.flush;
        pop  = (state_q == IDLE) && !empty_q && !bus.flush;
    end

    always_comb begin
        state_d = state_q;
        rdy_d   = rdy_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = ISSUE;
                    rdy_d   = 1'b1;
                    data_d  = mem_q[rd_ptr_q];
                end
            end
            ISSUE: begin
                rdy_d   = 1'b0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Flush only clears the queue; an issued byte and the FSM carry on untouched.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop)      count_d = count_q + CNT_ONE;
            else if (pop && !push) count_d = count_q - CNT_ONE;
            if (drop) ovf_d = 1'b1;
        end
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            rdy_q    <= 1'b0;
            data_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            rdy_q    <= rdy_d;
            data_q   <= data_d;
        end
    end

    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
    assign bus.tx_ready = rdy_q;
    assign bus.tx_data  = data_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted bytes are queued on push and popped by a
// transmitter model when tx_ready is seen; flag/count checks at the boundaries.
module tb_uart_tx_fifo;
    localparam int DL2 = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DEPTH_LOG2(DL2)) bif ();
    uart_tx_fifo #(.DEPTH_LOG2(DL2)) dut (.clk(clk), .reset(reset), .bus(bif));

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] sb [$];
    int busy_len = 3;
    int bcnt = 0;
    bit stall = 0;
    bit prev_rdy = 0;
    int rdy_cnt = 0;
    int rc0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    // Transmitter model, sampled at the negedge after each active edge.
    task automatic xmit_step();
        logic [7:0] e;
        if (reset) begin
            bif.tx_busy = 1'b0;
            bcnt = 0;
            prev_rdy = 0;
        end else begin
            if (bif.tx_ready) begin
                rdy_cnt++;
                chk("rdy_pulse", int'(prev_rdy), 0);
                chk("sb_nonempty", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("tx_data", int'(bif.tx_data), int'(e));
                end
                bif.tx_busy = 1'b1;
                bcnt = busy_len;
            end else if (bif.tx_busy && !stall) begin
                if (bcnt <= 1) bif.tx_busy = 1'b0;
                else bcnt--;
            end
            prev_rdy = bif.tx_ready;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        xmit_step();
    endtask

    task automatic push(input logic [7:0] b, input bit accept);
        bif.wr_en = 1'b1;
        bif.wr_data = b;
        if (accept) sb.push_back(b);
        tick();
        bif.wr_en = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (!(sb.size() == 0 && !bif.tx_busy && bif.empty && !bif.tx_ready) && n < limit) begin
            tick();
            n++;
        end
        chk("drain_timeout", int'(n < limit), 1);
        repeat (3) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bif.wr_en = 1'b0;
        bif.wr_data = 8'h00;
        bif.flush = 1'b0;
        bif.tx_busy = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_count", int'(bif.count), 0);
        chk("rst_empty", int'(bif.empty), 1);
        chk("rst_full", int'(bif.full), 0);
        chk("rst_ovf", int'(bif.overflow), 0);
        chk("rst_rdy", int'(bif.tx_ready), 0);
        chk("rst_data", int'(bif.tx_data), 0);

        // Single byte, long transmitter busy
        busy_len = 100;
        rc0 = rdy_cnt;
        push(8'h55, 1);
        chk("lat_count", int'(bif.count), 1);
        chk("lat_norody", int'(bif.tx_ready), 0);
        tick();
        chk("lat_rdy", int'(bif.tx_ready), 1);
        chk("lat_pop_cnt", int'(bif.count), 0);
        tick();
        chk("rdy_low", int'(bif.tx_ready), 0);
        chk("data_hold", int'(bif.tx_data), 8'h55);
        drain(400);
        chk("t1_empty", int'(bif.empty), 1);
        chk("t1_npulse", rdy_cnt - rc0, 1);

        // Order and pointer wrap across 40 bytes
        busy_len = 3;
        rc0 = rdy_cnt;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 16; i++)
                if (b*16 + i < 40) push(8'(b*16 + i), 1);
            drain(1000);
        end
        chk("t2_npulse", rdy_cnt - rc0, 40);

        // Overflow with transmitter stalled; the first byte goes in flight
        stall = 1;
        push(8'hEE, 1);
        repeat (4) tick();
        chk("t3_cnt0", int'(bif.count), 0);
        for (int i = 0; i < 16; i++) begin
            push(8'(8'h40 + i), 0);
            if (i == 14) chk("t3_notfull15", int'(bif.full), 0);
        end
        chk("t3_full", int'(bif.full), 1);
        chk("t3_cnt16", int'(bif.count), 16);
        chk("t3_noovf", int'(bif.overflow), 0);
        push(8'h50, 0);
        chk("t3_ovf", int'(bif.overflow), 1);
        chk("t3_cnt_drop", int'(bif.count), 16);
        push(8'h51, 0);
        chk("t3_cnt_drop2", int'(bif.count), 16);
        bif.flush = 1'b1;
        tick();
        bif.flush = 1'b0;
        chk("t3_fl_cnt", int'(bif.count), 0);
        chk("t3_fl_ovf", int'(bif.overflow), 0);
        chk("t3_fl_empty", int'(bif.empty), 1);
        chk("t3_fl_full", int'(bif.full), 0);

        // Push while full on the pop edge is dropped
        for (int i = 0; i < 16; i++) push(8'(8'h80 + i), 1);
        chk("t4_full", int'(bif.full), 1);
        bcnt = 0;
        stall = 0;
        tick();
        tick();
        push(8'hC0, 0);
        chk("t4_ovf", int'(bif.overflow), 1);
        chk("t4_cnt15", int'(bif.count), 15);
        chk("t4_rdy", int'(bif.tx_ready), 1);
        stall = 1;
        bif.flush = 1'b1;
        tick();
        bif.flush = 1'b0;
        sb.delete();
        chk("t4_fl_cnt", int'(bif.count), 0);
        push(8'h90, 1);
        push(8'h91, 1);
        push(8'h92, 1);
        chk("t4_cnt3", int'(bif.count), 3);
        bcnt = 0;
        stall = 0;
        tick();
        tick();
        push(8'h93, 1);
        chk("t4_pushpop", int'(bif.count), 3);
        chk("t4_rdy2", int'(bif.tx_ready), 1);
        drain(400);

        // Flush while a byte is in flight
        busy_len = 20;
        rc0 = rdy_cnt;
        push(8'hA5, 1);
        tick();
        tick();
        bif.flush = 1'b1;
        bif.wr_en = 1'b1;
        bif.wr_data = 8'h11;
        tick();
        bif.flush = 1'b0;
        bif.wr_en = 1'b0;
        chk("t5_ovf", int'(bif.overflow), 0);
        chk("t5_cnt", int'(bif.count), 0);
        drain(400);
        chk("t5_npulse", rdy_cnt - rc0, 1);

        // Reset mid-operation
        stall = 1;
        push(8'h60, 1);
        for (int i = 1; i < 6; i++) push(8'(8'h60 + i), 1);
        repeat (2) tick();
        chk("t6_cnt5", int'(bif.count), 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        stall = 0;
        chk("t6_count", int'(bif.count), 0);
        chk("t6_empty", int'(bif.empty), 1);
        chk("t6_full", int'(bif.full), 0);
        chk("t6_ovf", int'(bif.overflow), 0);
        chk("t6_rdy", int'(bif.tx_ready), 0);
        chk("t6_data", int'(bif.tx_data), 0);
        rc0 = rdy_cnt;
        repeat (10) tick();
        chk("t6_quiet", rdy_cnt - rc0, 0);
        push(8'h3C, 1);
        drain(400);
        chk("t6_npulse", rdy_cnt - rc0, 1);
        chk("sb_left", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
